// File: rtl/rob_core_if.sv
// Rename / writeback / operand-read / retire bundle of the reorder buffer.
interface rob_core_if #(
  parameter int unsigned ROB_SIZE = 16
);
  localparam int unsigned IW = $clog2(ROB_SIZE);

  logic          flush;
  logic          alloc_req0, alloc_req1;
  logic          alloc_dvalid0, alloc_dvalid1;
  logic [4:0]    alloc_daddr0, alloc_daddr1;
  logic          alloc_ready;
  logic [IW-1:0] alloc_num0, alloc_num1;
  logic          wb_en0, wb_en1;
  logic [IW-1:0] wb_num0, wb_num1;
  logic [31:0]   wb_data0, wb_data1;
  logic [IW-1:0] rd_num0, rd_num1, rd_num2, rd_num3;
  logic          rd_ready0, rd_ready1, rd_ready2, rd_ready3;
  logic [31:0]   rd_data0, rd_data1, rd_data2, rd_data3;
  logic          commit_en0, commit_en1;
  logic [4:0]    commit_addr0, commit_addr1;
  logic [IW-1:0] commit_num0, commit_num1;
  logic [31:0]   commit_data0, commit_data1;
  logic [1:0]    retire_cnt;
  logic          empty;

  modport master (
    output flush, alloc_req0, alloc_req1, alloc_dvalid0, alloc_dvalid1,
           alloc_daddr0, alloc_daddr1, wb_en0, wb_en1, wb_num0, wb_num1,
           wb_data0, wb_data1, rd_num0, rd_num1, rd_num2, rd_num3,
    input  alloc_ready, alloc_num0, alloc_num1, rd_ready0, rd_ready1,
           rd_ready2, rd_ready3, rd_data0, rd_data1, rd_data2, rd_data3,
           commit_en0, commit_en1, commit_addr0, commit_addr1, commit_num0,
           commit_num1, commit_data0, commit_data1, retire_cnt, empty
  );

  modport slave (
    input  flush, alloc_req0, alloc_req1, alloc_dvalid0, alloc_dvalid1,
           alloc_daddr0, alloc_daddr1, wb_en0, wb_en1, wb_num0, wb_num1,
           wb_data0, wb_data1, rd_num0, rd_num1, rd_num2, rd_num3,
    output alloc_ready, alloc_num0, alloc_num1, rd_ready0, rd_ready1,
           rd_ready2, rd_ready3, rd_data0, rd_data1, rd_data2, rd_data3,
           commit_en0, commit_en1, commit_addr0, commit_addr1, commit_num0,
           commit_num1, commit_data0, commit_data1, retire_cnt, empty
  );
endinterface

// File: rtl/rob_core.sv
// Reorder buffer: hands out ROB numbers, collects results, retires two per cycle in order.
module rob_core #(
  parameter int unsigned ROB_SIZE = 16
) (
  input logic       clk,
  input logic       resetn,
  rob_core_if.slave bus
);
  localparam int unsigned IW = $clog2(ROB_SIZE);
  localparam int unsigned PW = IW + 1;

  logic [PW-1:0]       head_q, head_d, tail_q, tail_d;
  logic [ROB_SIZE-1:0] valid_q, valid_d, done_q, done_d, dvalid_q, dvalid_d;
  logic [4:0]          daddr_q [ROB_SIZE];
  logic [4:0]          daddr_d [ROB_SIZE];
  logic [31:0]         data_q  [ROB_SIZE];
  logic [31:0]         data_d  [ROB_SIZE];

  logic [PW-1:0] count;
  logic [IW-1:0] slot0, slot1, tnum0, tnum1;
  logic          ret0, ret1, acc0, acc1, alloc_ok;

  // Occupancy, retire candidates and allocation acceptance from registered state.
  always_comb begin
    count    = tail_q - head_q;
    slot0    = head_q[IW-1:0];
    slot1    = slot0 + IW'(1);
    tnum0    = tail_q[IW-1:0];
    tnum1    = tnum0 + IW'(1);
    ret0     = valid_q[slot0] & done_q[slot0];
    ret1     = ret0 & valid_q[slot1] & done_q[slot1];
    alloc_ok = (count <= PW'(ROB_SIZE - 2));
    acc0     = bus.alloc_req0 & alloc_ok;
    acc1     = bus.alloc_req0 & bus.alloc_req1 & alloc_ok;
  end

  // Next state: flush wins; otherwise writeback, then retire, then allocate.
  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    valid_d  = valid_q;
    done_d   = done_q;
    dvalid_d = dvalid_q;
    daddr_d  = daddr_q;
    data_d   = data_q;
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      valid_d = '0;
      done_d  = '0;
    end else begin
      // Port 1 is applied last so it wins a same-entry collision.
      if (bus.wb_en0 && valid_q[bus.wb_num0]) begin
        done_d[bus.wb_num0] = 1'b1;
        data_d[bus.wb_num0] = bus.wb_data0;
      end
      if (bus.wb_en1 && valid_q[bus.wb_num1]) begin
        done_d[bus.wb_num1] = 1'b1;
        data_d[bus.wb_num1] = bus.wb_data1;
      end
      if (ret0) begin
        valid_d[slot0] = 1'b0;
        done_d[slot0]  = 1'b0;
      end
      if (ret1) begin
        valid_d[slot1] = 1'b0;
        done_d[slot1]  = 1'b0;
      end
      head_d = head_q + PW'(ret0) + PW'(ret1);
      // Free entries only: alloc_ok ignores same-cycle retirement.
      if (acc0) begin
        valid_d[tnum0]  = 1'b1;
        done_d[tnum0]   = 1'b0;
        dvalid_d[tnum0] = bus.alloc_dvalid0;
        daddr_d[tnum0]  = bus.alloc_daddr0;
      end
      if (acc1) begin
        valid_d[tnum1]  = 1'b1;
        done_d[tnum1]   = 1'b0;
        dvalid_d[tnum1] = bus.alloc_dvalid1;
        daddr_d[tnum1]  = bus.alloc_daddr1;
      end
      tail_d = tail_q + PW'(acc0) + PW'(acc1);
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Payload storage; meaningless while the entry is invalid, so never reset.
  always_ff @(posedge clk) begin
    dvalid_q <= dvalid_d;
    daddr_q  <= daddr_d;
    data_q   <= data_d;
  end

  assign bus.alloc_ready = alloc_ok;
  assign bus.alloc_num0  = tnum0;
  assign bus.alloc_num1  = tnum1;
  assign bus.empty       = (count == '0);
  assign bus.retire_cnt  = {1'b0, ret0} + {1'b0, ret1};

  assign bus.rd_ready0 = valid_q[bus.rd_num0] & done_q[bus.rd_num0];
  assign bus.rd_ready1 = valid_q[bus.rd_num1] & done_q[bus.rd_num1];
  assign bus.rd_ready2 = valid_q[bus.rd_num2] & done_q[bus.rd_num2];
  assign bus.rd_ready3 = valid_q[bus.rd_num3] & done_q[bus.rd_num3];
  assign bus.rd_data0  = data_q[bus.rd_num0];
  assign bus.rd_data1  = data_q[bus.rd_num1];
  assign bus.rd_data2  = data_q[bus.rd_num2];
  assign bus.rd_data3  = data_q[bus.rd_num3];

  // r0 is hardwired zero, so it is never released.
  assign bus.commit_en0   = ret0 & dvalid_q[slot0] & (daddr_q[slot0] != 5'd0);
  assign bus.commit_en1   = ret1 & dvalid_q[slot1] & (daddr_q[slot1] != 5'd0);
  assign bus.commit_addr0 = daddr_q[slot0];
  assign bus.commit_addr1 = daddr_q[slot1];
  assign bus.commit_num0  = slot0;
  assign bus.commit_num1  = slot1;
  assign bus.commit_data0 = data_q[slot0];
  assign bus.commit_data1 = data_q[slot1];
endmodule

// File: tb/tb_rob_core.sv
// Bench for rob_core: directed scenarios plus random traffic against a queue model.
module tb_rob_core;
  localparam int unsigned ROB_SIZE = 16;
  localparam int unsigned IW = $clog2(ROB_SIZE);

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  rob_core_if #(.ROB_SIZE(ROB_SIZE)) bus ();
  rob_core #(.ROB_SIZE(ROB_SIZE)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  // Program-ordered list of live instructions.
  typedef struct {
    int          num;
    bit          dvalid;
    int          daddr;
    bit          done;
    logic [31:0] data;
  } ent_t;

  ent_t rob[$];
  int   next_num;
  int   total = 0;
  int   bad = 0;

  function automatic int find(input int n);
    foreach (rob[i]) if (rob[i].num == n) return i;
    return -1;
  endfunction

  function automatic int exp_ret();
    int r = 0;
    if (rob.size() >= 1 && rob[0].done) begin
      r = 1;
      if (rob.size() >= 2 && rob[1].done) r = 2;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input logic [IW-1:0] n, input logic rdy, input logic [31:0] d);
    int i = find(int'(n));
    chk({tag, "_ready"}, 32'(rdy), (i >= 0 && rob[i].done) ? 32'd1 : 32'd0);
    if (i >= 0 && rob[i].done) chk({tag, "_data"}, d, rob[i].data);
  endtask

  task automatic check_all();
    int r = exp_ret();
    bit e0 = (r >= 1) && rob[0].dvalid && (rob[0].daddr != 0);
    bit e1 = (r >= 2) && rob[1].dvalid && (rob[1].daddr != 0);
    chk("alloc_ready", 32'(bus.alloc_ready), 32'((int'(ROB_SIZE) - rob.size()) >= 2));
    chk("alloc_num0", 32'(bus.alloc_num0), 32'(next_num));
    chk("alloc_num1", 32'(bus.alloc_num1), 32'((next_num + 1) % ROB_SIZE));
    chk("empty", 32'(bus.empty), 32'(rob.size() == 0));
    chk("retire_cnt", 32'(bus.retire_cnt), 32'(r));
    chk("commit_en0", 32'(bus.commit_en0), 32'(e0));
    chk("commit_en1", 32'(bus.commit_en1), 32'(e1));
    if (r >= 1) begin
      chk("commit_num0", 32'(bus.commit_num0), 32'(rob[0].num));
      chk("commit_data0", bus.commit_data0, rob[0].data);
      if (e0) chk("commit_addr0", 32'(bus.commit_addr0), 32'(rob[0].daddr));
    end
    if (r >= 2) begin
      chk("commit_num1", 32'(bus.commit_num1), 32'(rob[1].num));
      chk("commit_data1", bus.commit_data1, rob[1].data);
      if (e1) chk("commit_addr1", 32'(bus.commit_addr1), 32'(rob[1].daddr));
    end
    chk_rd("rd0", bus.rd_num0, bus.rd_ready0, bus.rd_data0);
    chk_rd("rd1", bus.rd_num1, bus.rd_ready1, bus.rd_data1);
    chk_rd("rd2", bus.rd_num2, bus.rd_ready2, bus.rd_data2);
    chk_rd("rd3", bus.rd_num3, bus.rd_ready3, bus.rd_data3);
  endtask

  task automatic apply_wb(input logic en, input logic [IW-1:0] n, input logic [31:0] d);
    int   i;
    ent_t e;
    if (en) begin
      i = find(int'(n));
      if (i >= 0) begin
        e = rob[i];
        e.done = 1'b1;
        e.data = d;
        rob[i] = e;
      end
    end
  endtask

  // Model step at the clock edge, using the inputs the DUT saw.
  task automatic model_update();
    int   r = exp_ret();
    bit   ok = (int'(ROB_SIZE) - rob.size()) >= 2;
    ent_t e;
    if (!resetn || bus.flush) begin
      rob.delete();
      next_num = 0;
      return;
    end
    apply_wb(bus.wb_en0, bus.wb_num0, bus.wb_data0);
    apply_wb(bus.wb_en1, bus.wb_num1, bus.wb_data1);
    repeat (r) void'(rob.pop_front());
    if (ok && bus.alloc_req0) begin
      e = '{num: next_num, dvalid: bus.alloc_dvalid0, daddr: int'(bus.alloc_daddr0), done: 1'b0, data: 32'h0};
      rob.push_back(e);
      next_num = (next_num + 1) % ROB_SIZE;
      if (bus.alloc_req1) begin
        e = '{num: next_num, dvalid: bus.alloc_dvalid1, daddr: int'(bus.alloc_daddr1), done: 1'b0, data: 32'h0};
        rob.push_back(e);
        next_num = (next_num + 1) % ROB_SIZE;
      end
    end
  endtask

  task automatic cycle();
    #1 check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    bus.flush = 1'b0;
    bus.alloc_req0 = 1'b0; bus.alloc_req1 = 1'b0;
    bus.alloc_dvalid0 = 1'b0; bus.alloc_dvalid1 = 1'b0;
    bus.alloc_daddr0 = 5'd0; bus.alloc_daddr1 = 5'd0;
    bus.wb_en0 = 1'b0; bus.wb_en1 = 1'b0;
    bus.wb_num0 = '0; bus.wb_num1 = '0;
    bus.wb_data0 = 32'h0; bus.wb_data1 = 32'h0;
  endtask

  task automatic alloc1(input logic dv, input int a);
    bus.alloc_req0 = 1'b1; bus.alloc_dvalid0 = dv; bus.alloc_daddr0 = 5'(a);
  endtask

  task automatic alloc2(input int a0, input int a1);
    alloc1(1'b1, a0);
    bus.alloc_req1 = 1'b1; bus.alloc_dvalid1 = 1'b1; bus.alloc_daddr1 = 5'(a1);
  endtask

  task automatic wb0(input int n, input logic [31:0] d);
    bus.wb_en0 = 1'b1; bus.wb_num0 = IW'(n); bus.wb_data0 = d;
  endtask

  task automatic wb1(input int n, input logic [31:0] d);
    bus.wb_en1 = 1'b1; bus.wb_num1 = IW'(n); bus.wb_data1 = d;
  endtask

  // Complete the oldest outstanding work until the buffer empties (bounded).
  task automatic drain();
    int guard = 0;
    int k;
    while (rob.size() > 0 && guard < 64) begin
      idle();
      k = 0;
      foreach (rob[i]) begin
        if (!rob[i].done && k < 2) begin
          if (k == 0) wb0(rob[i].num, $urandom);
          else        wb1(rob[i].num, $urandom);
          k++;
        end
      end
      cycle();
      guard++;
    end
    idle();
    #1 chk("drain_empty", 32'(bus.empty), 32'd1);
  endtask

  initial begin
    ent_t e;
    resetn = 1'b0;
    idle();
    bus.rd_num0 = IW'(0); bus.rd_num1 = IW'(1); bus.rd_num2 = IW'(2); bus.rd_num3 = IW'(3);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    rob.delete();
    next_num = 0;

    // Reset values
    #1;
    chk("rst_alloc_ready", 32'(bus.alloc_ready), 32'd1);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_commit_en0", 32'(bus.commit_en0), 32'd0);
    chk("rst_commit_en1", 32'(bus.commit_en1), 32'd0);
    chk("rst_retire_cnt", 32'(bus.retire_cnt), 32'd0);
    chk("rst_rd_ready0", 32'(bus.rd_ready0), 32'd0);

    // Dual allocation r3/r5
    alloc2(3, 5);
    #1;
    chk("dual_num0", 32'(bus.alloc_num0), 32'd0);
    chk("dual_num1", 32'(bus.alloc_num1), 32'd1);
    cycle();
    idle();
    bus.rd_num0 = IW'(0);
    #1;
    chk("after_num0", 32'(bus.alloc_num0), 32'd2);
    chk("after_empty", 32'(bus.empty), 32'd0);
    chk("after_rd_ready0", 32'(bus.rd_ready0), 32'd0);
    cycle();

    // Out-of-order completion, in-order retirement
    idle(); wb0(1, 32'hBEEF); cycle();
    idle();
    #1;
    chk("ooo_commit_en0", 32'(bus.commit_en0), 32'd0);
    chk("ooo_retire_cnt", 32'(bus.retire_cnt), 32'd0);
    wb0(0, 32'h1234); cycle();
    idle();
    #1;
    chk("pair_en0", 32'(bus.commit_en0), 32'd1);
    chk("pair_en1", 32'(bus.commit_en1), 32'd1);
    chk("pair_addr0", 32'(bus.commit_addr0), 32'd3);
    chk("pair_addr1", 32'(bus.commit_addr1), 32'd5);
    chk("pair_data0", bus.commit_data0, 32'h1234);
    chk("pair_data1", bus.commit_data1, 32'hBEEF);
    chk("pair_retire_cnt", 32'(bus.retire_cnt), 32'd2);
    cycle();
    idle();
    #1 chk("pair_empty", 32'(bus.empty), 32'd1);

    // Fill to 15, stall, release one, then fill to full
    for (int k = 0; k < 7; k++) begin
      idle(); alloc2(2 * k + 1, 2 * k + 2); cycle();
    end
    idle(); alloc1(1'b1, 9); cycle();
    idle(); alloc2(10, 11);
    #1 chk("fill15_ready", 32'(bus.alloc_ready), 32'd0);
    cycle();
    idle(); wb0(rob[0].num, 32'hCAFE0001); cycle();
    idle();
    #1;
    chk("fill15_retire", 32'(bus.retire_cnt), 32'd1);
    chk("fill15_still_stalled", 32'(bus.alloc_ready), 32'd0);
    cycle();
    idle();
    #1 chk("fill14_ready", 32'(bus.alloc_ready), 32'd1);
    alloc2(12, 13); cycle();
    idle();
    #1;
    chk("full_not_empty", 32'(bus.empty), 32'd0);
    chk("full_ready", 32'(bus.alloc_ready), 32'd0);
    drain();

    // Sequential traffic across the number wrap
    for (int k = 0; k < 40; k++) begin
      idle();
      if ((int'(ROB_SIZE) - rob.size()) >= 2) alloc1(1'b1, int'($urandom_range(1, 31)));
      foreach (rob[i]) if (!rob[i].done && !bus.wb_en0) wb0(rob[i].num, $urandom);
      bus.rd_num0 = IW'(k); bus.rd_num1 = IW'(k + 15);
      cycle();
    end
    drain();

    // Destination r0 and no destination never release a GPR
    idle(); alloc1(1'b1, 0); cycle();
    idle(); wb0(rob[0].num, 32'h55); cycle();
    idle();
    #1;
    chk("r0_retire_cnt", 32'(bus.retire_cnt), 32'd1);
    chk("r0_commit_en0", 32'(bus.commit_en0), 32'd0);
    cycle();
    idle(); alloc1(1'b0, 7); cycle();
    idle(); wb0(rob[0].num, 32'h66); cycle();
    idle();
    #1;
    chk("nodest_retire_cnt", 32'(bus.retire_cnt), 32'd1);
    chk("nodest_commit_en0", 32'(bus.commit_en0), 32'd0);
    cycle();

    // Flush with six live entries plus same-cycle alloc and writeback
    for (int k = 0; k < 3; k++) begin
      idle(); alloc2(20 + k, 24 + k); cycle();
    end
    idle(); wb0(rob[3].num, 32'h77); cycle();
    idle(); alloc2(1, 2); wb0(rob[4].num, 32'h88); bus.flush = 1'b1;
    bus.rd_num0 = IW'(rob[0].num); bus.rd_num1 = IW'(rob[3].num);
    bus.rd_num2 = IW'(rob[4].num); bus.rd_num3 = IW'(rob[5].num);
    cycle();
    idle();
    #1;
    chk("flush_empty", 32'(bus.empty), 32'd1);
    chk("flush_num0", 32'(bus.alloc_num0), 32'd0);
    chk("flush_rd_ready0", 32'(bus.rd_ready0), 32'd0);
    chk("flush_rd_ready1", 32'(bus.rd_ready1), 32'd0);
    chk("flush_rd_ready2", 32'(bus.rd_ready2), 32'd0);
    chk("flush_rd_ready3", 32'(bus.rd_ready3), 32'd0);
    chk("flush_commit_en0", 32'(bus.commit_en0), 32'd0);
    chk("flush_retire_cnt", 32'(bus.retire_cnt), 32'd0);
    cycle();

    // Both writeback ports hit entry 4: port 1 wins
    for (int k = 0; k < 3; k++) begin
      idle(); alloc2(1 + k, 4 + k); cycle();
    end
    idle(); wb0(4, 32'hA); wb1(4, 32'hB); cycle();
    idle();
    bus.rd_num0 = IW'(4);
    #1;
    chk("dualwb_ready", 32'(bus.rd_ready0), 32'd1);
    chk("dualwb_data", bus.rd_data0, 32'hB);
    cycle();
    drain();

    // Random traffic with occasional flush and one mid-run reset
    for (int n = 0; n < 500; n++) begin
      idle();
      if ($urandom_range(0, 3) != 0) begin
        alloc1($urandom_range(0, 3) != 0, int'($urandom_range(0, 31)));
        if ($urandom_range(0, 1) == 1) begin
          bus.alloc_req1 = 1'b1;
          bus.alloc_dvalid1 = $urandom_range(0, 3) != 0;
          bus.alloc_daddr1 = 5'($urandom_range(0, 31));
        end
      end
      if (rob.size() > 0 && $urandom_range(0, 2) != 0) begin
        e = rob[$urandom_range(0, (rob.size() > 4) ? 3 : rob.size() - 1)];
        wb0(e.num, $urandom);
      end else if ($urandom_range(0, 4) == 0) begin
        wb0(int'($urandom_range(0, ROB_SIZE - 1)), $urandom);
      end
      if (rob.size() > 0 && $urandom_range(0, 1) == 1) begin
        e = rob[$urandom_range(0, rob.size() - 1)];
        wb1(e.num, $urandom);
      end
      bus.rd_num0 = IW'($urandom_range(0, ROB_SIZE - 1));
      bus.rd_num1 = IW'($urandom_range(0, ROB_SIZE - 1));
      bus.rd_num2 = (rob.size() > 0) ? IW'(rob[0].num) : IW'(0);
      bus.rd_num3 = (rob.size() > 1) ? IW'(rob[rob.size() - 1].num) : IW'(5);
      bus.flush = ($urandom_range(0, 49) == 0);
      if (n == 250) resetn = 1'b0;
      cycle();
      resetn = 1'b1;
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rob_core.md
Name: rob_core

Overview:
- Reorder buffer: allocation and retirement side of the register-rename protocol.
- Hands out ROB numbers to Rename (wnum0/wnum1 of the GPR status table).
- Collects execution results and exposes operand value and ready state per ROB number.
- Retires up to two entries per cycle in program order, driving the table's commit_addr/num/en release ports and the architectural register-file write.

Parameters:
- ROB_SIZE, 16, number of entries; power of two, ≥4; equals the `ROB_SIZE` define.
- IW, $clog2(ROB_SIZE), ROB number width (derived; not overridden).

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- flush  in  1  discard all entries.
- alloc_req0  in  1  Rename slot 0 requests an entry.
- alloc_req1  in  1  Rename slot 1 requests an entry; only legal with alloc_req0.
- alloc_dvalid0/1  in  1  slot has a GPR destination.
- alloc_daddr0/1  in  5  destination GPR.
- alloc_ready  out  1  two entries guaranteed free this cycle.
- alloc_num0/1  out  IW  ROB numbers for slots 0/1.
- wb_en0/1  in  1  writeback valid.
- wb_num0/1  in  IW  target entry.
- wb_data0/1  in  32  result.
- rd_num0..3  in  IW  operand lookup numbers.
- rd_ready0..3  out  1  entry done.
- rd_data0..3  out  32  entry result.
- commit_en0/1  out  1  release GPR (to status table).
- commit_addr0/1  out  5  GPR retired.
- commit_num0/1  out  IW  ROB number retired.
- commit_data0/1  out  32  value for the architectural register file.
- retire_cnt  out  2  entries retired this cycle (0..2).
- empty  out  1  no valid entries.

Behaviour:
- State per entry: valid, done, dvalid, daddr[4:0], data[31:0].
- Pointers head and tail, each IW+1 bits (wrap bit); count = tail − head.
- Reset (resetn=0 at posedge):
  - head=tail=0; all valid/done=0; data is don't-care.
  - Outputs after reset: alloc_ready=1, empty=1, all commit_en=0, retire_cnt=0, rd_ready=0.
- Allocation:
  - alloc_num0 = tail[IW-1:0]; alloc_num1 = tail+1, combinational.
  - alloc_ready = (ROB_SIZE − count) ≥ 2, from registered count; same-cycle retirement is not credited.
  - A request is accepted only when alloc_ready=1. Requests while alloc_ready=0 are ignored; Rename stalls.
  - On acceptance, the entry is written valid=1, done=0 with dvalid and daddr. tail advances by req0+req1.
- Writeback:
  - On wb_enK, entry wb_numK gets done=1 and data=wb_dataK.
  - Writeback to an invalid entry is ignored.
  - If both ports target the same entry, port 1 wins.
  - Results are visible on rd_* the next cycle; no same-cycle bypass.
- Read ports:
  - Combinational: rd_readyK = valid & done of entry rd_numK; rd_dataK = its data.
- Commit, combinational from registered state:
  - slot0 = entry head; slot1 = entry head+1.
  - ret0 = valid & done of slot0. ret1 = ret0 & valid & done of slot1.
  - commit_enK = retK & dvalid & (daddr≠0). commit_addrK, commit_numK and commit_dataK come from the slot.
  - At the posedge: retired entries get valid=0, head advances by retire_cnt = ret0+ret1.
  - Strictly in order: a done slot1 never retires while slot0 is not done.
  - Pointer arithmetic wraps modulo 2·ROB_SIZE. Full = count==ROB_SIZE; empty = count==0.
- Simultaneous events:
  - Alloc, writeback and commit in the same cycle all take effect.
  - Allocation never overwrites an entry retiring that cycle, because alloc_ready uses the pre-retire count.
- Flush (top priority after reset):
  - At the posedge: all valid/done=0, head=tail=0; that cycle's alloc and writeback are discarded.
  - Commit outputs in the flush cycle are still driven from the pre-flush state. The consumer sees flush at the same edge, and the status table's flush overrides the release.
- Reset mid-operation behaves as flush plus the reset values above.

Test Plan:
- Reset, then dual alloc with dests r3/r5 → alloc_num0=0, alloc_num1=1. Next cycle alloc_num0=2, empty=0, rd_ready0 for num 0 is 0.
- Writeback to num1 only (data 0xBEEF) → commit_en0=0, retire_cnt=0. Then writeback to num0 (0x1234) → next cycle commit_en0=commit_en1=1, addr 3/5, data 0x1234/0xBEEF, retire_cnt=2; following cycle empty=1.
- Fill 15 entries (ROB_SIZE=16) → alloc_ready=0. A single retirement leaves count 14 → alloc_ready=1 the cycle after.
- Run 40 sequential alloc/wb/commit cycles → ROB numbers wrap 15→0; commits stay in order; the wrap bit distinguishes full from empty.
- An entry with dest r0 or dvalid=0 is done → retire_cnt=1, commit_en0=0.
- Flush with 6 live entries plus a same-cycle alloc and writeback → next cycle empty=1, alloc_num0=0, all rd_ready=0, no commits.
- Both writeback ports target num 4 with 0xA and 0xB → rd_data for num 4 is 0xB.
